// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry accumulator slice.
package rca_pkg;

  // Datapath width of the existing RCA_16bit adder.
  localparam int unsigned RCA_DATA_W = 16;

  // Accumulator FSM state encodings.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/RCA_16bit.sv
// 16-bit ripple-carry adder: carry walks bit 0 to bit 15 through full-adder cells.
module RCA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Chain of full adders; c carries between cells.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca16_accumulator.sv
// Burst accumulator behind RCA_16bit: sums count_n operands via valid/ready,
// counting carry-outs (saturating) and flagging any carry (sticky).
module rca16_accumulator
  import rca_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count_n,
  input  logic              cin_init,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] acc_out,
  output logic [CNT_W-1:0]  carry_cnt,
  output logic              ovf
);

  // The adder is fixed-width; any other datapath width cannot be built.
  if (DATA_W != RCA_DATA_W) begin : gen_width_check
    $error("rca16_accumulator: DATA_W must equal the RCA_16bit width");
  end

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  carry_cnt_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              first_q;
  logic              cin_init_q;

  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              transfer;

  assign transfer = in_valid & in_ready;

  // Carry-in only ever applies to the first accepted operand of a burst.
  RCA_16bit u_rca (
    .a    (acc_q),
    .b    (in_data),
    .cin  (first_q & cin_init_q),
    .sum  (sum),
    .cout (cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (count_n != '0) ? StAccum : StDone;
        end
      end
      StAccum: begin
        if (transfer && (remaining_q == CNT_W'(1))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready = (state_q == StAccum);
    busy     = (state_q == StAccum) || (state_q == StDone);
    done     = (state_q == StDone);
  end

  // Datapath: clear on start, accumulate on each transfer, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      carry_cnt_q <= '0;
      ovf_q       <= 1'b0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      cin_init_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        acc_q       <= '0;
        carry_cnt_q <= '0;
        ovf_q       <= 1'b0;
        if (count_n != '0) begin
          remaining_q <= count_n;
          cin_init_q  <= cin_init;
          first_q     <= 1'b1;
        end
      end else if (transfer) begin
        acc_q       <= sum;
        ovf_q       <= ovf_q | cout;
        first_q     <= 1'b0;
        remaining_q <= remaining_q - CNT_W'(1);
        if (cout && (carry_cnt_q != '1)) begin
          carry_cnt_q <= carry_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign acc_out   = acc_q;
  assign carry_cnt = carry_cnt_q;
  assign ovf       = ovf_q;

endmodule
